// File: rtl/openframe_gpio_cfg_serializer.sv
// Per-pad configuration store plus serial transmitter for the daisy-chained pad
// configuration shift registers. The highest pad goes first, MSB first, and one load pulse follows.
module openframe_gpio_cfg_serializer #(
  parameter int                  NUM_PADS  = 44,
  parameter int                  CFG_BITS  = 13,
  parameter logic [CFG_BITS-1:0] CFG_RESET = CFG_BITS'(13'h0403),
  parameter int                  AW        = 6
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data
);

  localparam int                BW       = $clog2(CFG_BITS);
  localparam logic [AW-1:0]     LAST_PAD = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0]     LAST_BIT = BW'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } state_t;

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [AW-1:0]         pad_q, pad_d;
  logic                  sclk_q, sclk_d;
  logic                  sload_q, sload_d;
  logic                  sdata_q, sdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CFG_BITS-1:0]   rdata_q, rdata_d;
  logic [CFG_BITS-1:0]   cfg_q [NUM_PADS];
  logic [CFG_BITS-1:0]   cfg_d [NUM_PADS];

  logic addr_ok;
  logic wr_en;

  assign addr_ok = (cfg_addr <= LAST_PAD);
  assign wr_en   = cfg_we && (state_q == ST_IDLE) && addr_ok;

  always_comb begin
    cfg_d = cfg_q;
    if (wr_en) begin
      cfg_d[cfg_addr] = cfg_wdata;
    end
    rdata_d = addr_ok ? cfg_q[cfg_addr] : '0;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    pad_d   = pad_q;
    sclk_d  = 1'b0;
    sload_d = 1'b0;
    sdata_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          phase_d = 1'b0;
          bit_d   = LAST_BIT;
          pad_d   = LAST_PAD;
          // cfg_d so that a write in the same cycle as start is streamed
          sdata_d = cfg_d[LAST_PAD][LAST_BIT];
        end
      end
      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
          sdata_d = sdata_q;
        end else if ((bit_q == '0) && (pad_q == '0)) begin
          state_d = ST_LOAD;
          sload_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (bit_q == '0) begin
            bit_d = LAST_BIT;
            pad_d = pad_q - 1'b1;
          end else begin
            bit_d = bit_q - 1'b1;
          end
          sdata_d = cfg_q[pad_d][bit_d];
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      bit_q   <= '0;
      pad_q   <= '0;
      sclk_q  <= 1'b0;
      sload_q <= 1'b0;
      sdata_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        cfg_q[i] <= CFG_RESET;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      pad_q   <= pad_d;
      sclk_q  <= sclk_d;
      sload_q <= sload_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_PADS; i++) begin
        cfg_q[i] <= cfg_d[i];
      end
    end
  end

  assign cfg_rdata    = rdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign serial_clock = sclk_q;
  assign serial_load  = sload_q;
  assign serial_data  = sdata_q;

endmodule

// File: tb/tb_openframe_gpio_cfg_serializer.sv
// Directed bench for openframe_gpio_cfg_serializer: decodes the serial stream
// back into per-pad words and compares against a bench-side config model.
module tb_openframe_gpio_cfg_serializer;

  localparam int N = 44;
  localparam int B = 13;
  localparam int NBITS = N * B;
  localparam int LOAD_CYC = 2 * NBITS + 1;
  localparam logic [B-1:0] RST_WORD = 13'h0403;

  logic         clk = 1'b0;
  logic         resetb = 1'b1;
  logic         cfg_we = 1'b0;
  logic [5:0]   cfg_addr = '0;
  logic [B-1:0] cfg_wdata = '0;
  logic [B-1:0] cfg_rdata;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic         serial_clock;
  logic         serial_load;
  logic         serial_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [B-1:0] exp_cfg [N];

  openframe_gpio_cfg_serializer dut (
    .clk          (clk),
    .resetb       (resetb),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .serial_clock (serial_clock),
    .serial_load  (serial_load),
    .serial_data  (serial_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input logic [5:0] addr, input logic [B-1:0] data);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (int'(addr) < N) exp_cfg[addr] = data;
    $display("write pad %0d <= 0x%0h", addr, data);
  endtask

  task automatic read_cfg(input logic [5:0] addr, output logic [B-1:0] data);
    @(negedge clk);
    cfg_addr = addr;
    @(negedge clk);
    data = cfg_rdata;
    $display("read  pad %0d => 0x%0h", addr, data);
  endtask

  // start (optionally with a same-cycle write), run one full stream and decode it
  task automatic run_stream(input bit inject, input bit pre_we, input logic [5:0] pre_addr,
                            input logic [B-1:0] pre_data, input string name);
    logic [B-1:0] rx [N];
    int nbits = 0, nload = 0, ndone = 0, nbusy = 0;
    int load_cyc = -1, done_cyc = -1, load_dirty = 0;
    logic prev_clk = 1'b0;
    for (int p = 0; p < N; p++) rx[p] = 'x;
    @(negedge clk);
    start = 1'b1;
    cfg_we = pre_we;
    cfg_addr = pre_addr;
    cfg_wdata = pre_data;
    for (int cyc = 1; cyc <= LOAD_CYC + 15; cyc++) begin
      @(negedge clk);
      start = inject && (cyc == 10);
      cfg_we = inject && (cyc == 20);
      cfg_addr = 6'd5;
      cfg_wdata = 13'h0AAA;
      if (serial_clock && !prev_clk) begin
        if (nbits < NBITS) rx[N - 1 - nbits / B][B - 1 - nbits % B] = serial_data;
        nbits++;
      end
      prev_clk = serial_clock;
      if (serial_load) begin
        nload++;
        load_cyc = cyc;
        if (serial_clock || serial_data) load_dirty++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (busy) nbusy++;
    end
    cfg_we = 1'b0;
    start = 1'b0;
    $display("stream %s: %0d bits, load at %0d, done at %0d", name, nbits, load_cyc, done_cyc);
    check({name, ".bits"}, nbits, NBITS);
    check({name, ".load_cyc"}, load_cyc, LOAD_CYC);
    check({name, ".done_cyc"}, done_cyc, LOAD_CYC + 1);
    check({name, ".nload"}, nload, 1);
    check({name, ".ndone"}, ndone, 1);
    check({name, ".busy_cycles"}, nbusy, LOAD_CYC);
    check({name, ".load_quiet"}, load_dirty, 0);
    for (int p = 0; p < N; p++) begin
      check($sformatf("%s.pad%0d", name, p), 32'(rx[p]), 32'(exp_cfg[p]));
    end
  endtask

  initial begin
    logic [B-1:0] rd;
    int nload, ndone, nbusy;
    for (int p = 0; p < N; p++) exp_cfg[p] = RST_WORD;

    #2 resetb = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sclk", serial_clock, 0);
    check("rst.sload", serial_load, 0);
    check("rst.sdata", serial_data, 0);
    check("rst.rdata", cfg_rdata, 0);
    repeat (3) @(negedge clk);
    resetb = 1'b1;

    read_cfg(6'd0, rd);
    check("rst.pad0", rd, RST_WORD);
    read_cfg(6'd43, rd);
    check("rst.pad43", rd, RST_WORD);

    run_stream(1'b0, 1'b0, 6'd0, '0, "default");

    write_cfg(6'd0, 13'h1FFF);
    exp_cfg[43] = 13'h0001;
    run_stream(1'b0, 1'b1, 6'd43, 13'h0001, "edges");
    read_cfg(6'd43, rd);
    check("same_cycle.pad43", rd, 13'h0001);

    run_stream(1'b1, 1'b0, 6'd0, '0, "busy_ops");
    read_cfg(6'd5, rd);
    check("busy_write.pad5", rd, RST_WORD);

    // reset mid-stream at cycle 500
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc < 500; cyc++) @(negedge clk);
    check("mid.busy_before", busy, 1);
    @(negedge clk);
    resetb = 1'b0;
    #1;
    check("mid.busy", busy, 0);
    check("mid.sclk", serial_clock, 0);
    check("mid.sdata", serial_data, 0);
    check("mid.sload", serial_load, 0);
    for (int p = 0; p < N; p++) exp_cfg[p] = RST_WORD;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    nload = 0;
    ndone = 0;
    nbusy = 0;
    for (int cyc = 0; cyc < LOAD_CYC + 10; cyc++) begin
      @(negedge clk);
      if (serial_load) nload++;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    $display("reset abort: %0d loads, %0d dones, %0d busy cycles after release", nload, ndone, nbusy);
    check("mid.no_load", nload, 0);
    check("mid.no_done", ndone, 0);
    check("mid.no_busy", nbusy, 0);
    read_cfg(6'd0, rd);
    check("mid.pad0", rd, RST_WORD);
    read_cfg(6'd43, rd);
    check("mid.pad43", rd, RST_WORD);

    write_cfg(6'd50, 13'h1234);
    read_cfg(6'd50, rd);
    check("oob.rdata", rd, 0);
    read_cfg(6'd43, rd);
    check("oob.pad43", rd, exp_cfg[43]);

    run_stream(1'b0, 1'b0, 6'd0, '0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
